// File: rtl/ifetch_buf_pkg.sv
// Shared constants for the instruction-fetch buffer and its helpers.
package ifetch_buf_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifetch_buf_if.sv
// Decode-side and external instruction-port signals of the fetch buffer.
interface ifetch_buf_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic            br_en;
    logic [XLEN-1:0] br_addr;
    logic            ins_valid;
    logic [XLEN-1:0] ins_out;
    logic [XLEN-1:0] ins_pc;
    logic            exIns_ren;
    logic [XLEN-1:0] exIns_addr;
    logic            exIns_valid;
    logic [XLEN-1:0] exIns_in;

    modport master (
        input  stall, br_en, br_addr, exIns_valid, exIns_in,
        output ins_valid, ins_out, ins_pc, exIns_ren, exIns_addr
    );

    modport slave (
        output stall, br_en, br_addr, exIns_valid, exIns_in,
        input  ins_valid, ins_out, ins_pc, exIns_ren, exIns_addr
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is read straight from storage.
module sync_fifo
    import ifetch_buf_pkg::*;
#(
    parameter  int unsigned W     = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifetch_buf.sv
// In-order prefetching fetch unit: credit-limited requests, response queue, branch flush.
module ifetch_buf
    import ifetch_buf_pkg::*;
#(
    parameter int unsigned    XLEN     = XLEN_DEF,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic         clk,
    input  logic         nrst,
    ifetch_buf_if.master bus
);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] fetch_pc, fetch_pc_n;
    logic            run, run_n;
    logic [CW-1:0]   inflight, inflight_n;
    logic [CW-1:0]   drop, drop_n;

    logic            req;
    logic            resp_ok;
    logic            q_push, q_pop, q_full, q_empty;
    logic [CW-1:0]   q_count;
    logic [2*XLEN-1:0] q_head;
    logic            pc_push, pc_pop, pc_full, pc_empty;
    logic [CW-1:0]   pc_count;
    logic [XLEN-1:0] pc_head;
    logic            unused_br;

    assign unused_br = ^bus.br_addr[1:0];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_pc <= RESET_PC;
            run      <= 1'b0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            fetch_pc <= fetch_pc_n;
            run      <= run_n;
            inflight <= inflight_n;
            drop     <= drop_n;
        end
    end

    // Credit rule: requests in flight plus queued entries never exceed DEPTH.
    always_comb begin
        resp_ok    = bus.exIns_valid && (inflight != '0);
        req        = run && !bus.br_en &&
                     ((SW'(inflight) + SW'(q_count)) < SW'(DEPTH));
        fetch_pc_n = fetch_pc;
        run_n      = 1'b1;
        inflight_n = inflight + CW'(req) - CW'(resp_ok);
        drop_n     = drop;
        if (bus.br_en) begin
            fetch_pc_n = {bus.br_addr[XLEN-1:2], 2'b00};
            drop_n     = inflight - CW'(resp_ok);
        end else begin
            if (req) fetch_pc_n = fetch_pc + XLEN'(4);
            if (resp_ok && (drop != '0)) drop_n = drop - CW'(1);
        end
    end

    assign pc_push = req;
    assign pc_pop  = resp_ok && (drop == '0);
    assign q_push  = resp_ok && (drop == '0) && !bus.br_en;
    assign q_pop   = !q_empty && !bus.stall && !bus.br_en;

    sync_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (pc_push),
        .pop   (pc_pop),
        .flush (bus.br_en),
        .din   (fetch_pc),
        .full  (pc_full),
        .empty (pc_empty),
        .count (pc_count),
        .head  (pc_head)
    );

    sync_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_ins_q (
        .clk   (clk),
        .nrst  (nrst),
        .push  (q_push),
        .pop   (q_pop),
        .flush (bus.br_en),
        .din   ({bus.exIns_in, pc_head}),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count),
        .head  (q_head)
    );

    assign bus.exIns_ren  = req;
    assign bus.exIns_addr = fetch_pc;
    assign bus.ins_valid  = !q_empty;
    assign bus.ins_out    = q_empty ? XLEN'(NOP_INST) : q_head[2*XLEN-1:XLEN];
    assign bus.ins_pc     = q_empty ? '0 : q_head[XLEN-1:0];

`ifndef SYNTHESIS
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!nrst)
        bus.exIns_valid |-> (inflight != '0));
    a_pc_track: assert property (@(posedge clk) disable iff (!nrst)
        pc_count == CW'(inflight - drop));
    a_pc_match: assert property (@(posedge clk) disable iff (!nrst)
        pc_pop |-> !pc_empty);
    a_pc_room: assert property (@(posedge clk) disable iff (!nrst)
        pc_push |-> !pc_full);
    a_q_room: assert property (@(posedge clk) disable iff (!nrst)
        (q_push && !q_pop) |-> !q_full);
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// Self-checking bench for ifetch_buf: vector table, directed corner cases, random traffic.
module tb_ifetch_buf;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic        st;
        logic        ren;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] out;
    } vec_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    ifetch_buf_if #(.XLEN(32)) bus ();

    ifetch_buf #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_taken = 0;
    req_t        pend[$];
    logic [31:0] exp_req = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    logic        resp_now;
    logic        s_ren, s_valid;
    logic [31:0] s_addr, s_pc, s_out;
    vec_t        tbl[12];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // One cycle: memory model drives a response, outputs are sampled, and the
    // stream model checks requests and accepted instructions.
    task automatic step(input logic st, input logic br, input logic [31:0] ba);
        @(negedge clk);
        bus.stall   = st;
        bus.br_en   = br;
        bus.br_addr = ba;
        resp_now    = 1'b0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus.exIns_valid = 1'b1;
            bus.exIns_in    = pend[0].addr ^ KEY;
            void'(pend.pop_front());
            resp_now = 1'b1;
        end else begin
            bus.exIns_valid = 1'b0;
            bus.exIns_in    = $urandom;
        end
        #1;
        s_ren   = bus.exIns_ren;
        s_addr  = bus.exIns_addr;
        s_valid = bus.ins_valid;
        s_pc    = bus.ins_pc;
        s_out   = bus.ins_out;
        if (br) chk("ren_during_branch", 32'(s_ren), 32'd0);
        if (s_ren) begin
            chk("req_addr", s_addr, exp_req);
            exp_req = exp_req + 32'd4;
            pend.push_back('{addr: s_addr, due: cyc + lat});
            chk("inflight_cap", 32'(pend.size() <= DEPTH), 32'd1);
        end
        if (s_valid) begin
            chk("stream_pc", s_pc, exp_pc);
            chk("stream_data", s_out, s_pc ^ KEY);
            if (!st && !br) begin
                exp_pc = exp_pc + 32'd4;
                n_taken++;
            end
        end else begin
            chk("idle_out_nop", s_out, NOP);
            chk("idle_pc_zero", s_pc, 32'h0);
        end
        if (br) begin
            exp_req = {ba[31:2], 2'b00};
            exp_pc  = {ba[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        nrst            = 1'b0;
        bus.stall       = 1'b0;
        bus.br_en       = 1'b0;
        bus.br_addr     = 32'h0;
        bus.exIns_valid = 1'b0;
        bus.exIns_in    = 32'h0;
        pend.delete();
        #1;
        chk("rst_ren", 32'(bus.exIns_ren), 32'd0);
        chk("rst_addr", bus.exIns_addr, 32'h0);
        chk("rst_valid", 32'(bus.ins_valid), 32'd0);
        chk("rst_out", bus.ins_out, NOP);
        chk("rst_pc", bus.ins_pc, 32'h0);
        repeat (2) @(negedge clk);
        #2;
        nrst    = 1'b1;
        exp_req = 32'h0;
        exp_pc  = 32'h0;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc);
        int k = 0;
        while (!s_valid && k < 20) begin
            step(1'b0, 1'b0, 32'h0);
            k++;
        end
        chk({name, "_valid"}, 32'(s_valid), 32'd1);
        chk({name, "_pc"}, s_pc, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, NOP};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00, NOP};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 32'hA5A5_0000};
        tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04, 32'hA5A5_0004};
        tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08, 32'hA5A5_0008};
        tbl[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C, 32'hA5A5_000C};
        tbl[6]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10, 32'hA5A5_0010};
        tbl[7]  = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 32'hA5A5_0010};
        tbl[8]  = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10, 32'hA5A5_0010};
        tbl[9]  = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10, 32'hA5A5_0010};
        tbl[10] = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 32'hA5A5_0010};
        tbl[11] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h14, 32'hA5A5_0014};

        apply_reset();

        lat = 1;
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].st, 1'b0, 32'h0);
            chk($sformatf("vec%0d_ren", i), 32'(s_ren), 32'(tbl[i].ren));
            chk($sformatf("vec%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d_pc", i), s_pc, tbl[i].pc);
            chk($sformatf("vec%0d_out", i), s_out, tbl[i].out);
        end

        // Redirect with several slow responses outstanding.
        lat = 3;
        repeat (4) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0103);
        step(1'b0, 1'b0, 32'h0);
        chk("br_first_ren", 32'(s_ren), 32'd1);
        chk("br_first_addr", s_addr, 32'h0000_0100);
        wait_valid("br_target", 32'h0000_0100);

        // Redirect under stall with a response landing in the same cycle.
        lat = 1;
        begin
            int k = 0;
            step(1'b0, 1'b0, 32'h0);
            while (!s_ren && k < 10) begin
                step(1'b0, 1'b0, 32'h0);
                k++;
            end
        end
        step(1'b1, 1'b1, 32'h0000_0200);
        chk("stall_br_resp_same_cycle", 32'(resp_now), 32'd1);
        step(1'b1, 1'b0, 32'h0);
        chk("stall_br_queue_empty", 32'(s_valid), 32'd0);
        chk("stall_br_next_addr", s_addr, 32'h0000_0200);
        wait_valid("stall_br_target", 32'h0000_0200);

        // Address wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_req0", s_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_req1", s_addr, 32'h0000_0000);
        chk("wrap_req1_ren", 32'(s_ren), 32'd1);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_t3_valid", 32'(s_valid), 32'd1);
        chk("wrap_pc0", s_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_pc1", s_pc, 32'h0000_0000);

        // Random stall/branch/latency traffic with an asynchronous reset midway.
        n_taken = 0;
        for (int i = 0; i < 400; i++) begin
            logic        st;
            logic        br;
            logic [31:0] ba;
            if (i == 200) begin
                apply_reset();
                step(1'b0, 1'b0, 32'h0);
                chk("midrst_first_addr", s_addr, 32'h0);
                chk("midrst_first_ren", 32'(s_ren), 32'd1);
            end
            st  = ($urandom_range(9) < 3);
            br  = ($urandom_range(31) == 0);
            ba  = $urandom;
            lat = 1 + int'($urandom_range(3));
            step(st, br, ba);
        end
        chk("random_progress", 32'(n_taken > 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
